// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment vectors are ordered abcdefg, with a in bit 6 and g in bit 0.
package seg_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_e;

    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // Glyphs 0-9, A, b, C, d, E, F in abcdefg order
    localparam logic [6:0] GLYPH [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

endpackage

// File: rtl/Bublik_segment.sv
// Combinational hex nibble to seven-segment pattern decoder.
// Output is active-high, abcdefg order.
module Bublik_segment
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = GLYPH[hex_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit seven-segment display.
// Display data is double-buffered and committed at frame boundaries.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_tick,
    output logic                    load_ack
);

    localparam int CW = $clog2(PRESCALE);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] SHOW_LAST = CW'(PRESCALE - BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    state_e                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] act_dig_q, act_dig_d, pend_dig_q;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q;
    logic                    pend_vld_q;
    logic                    frame_end, commit, show_d, tick_d;
    logic [3:0]              nib_d;
    logic [6:0]              dec_seg;
    logic [NUM_DIGITS-1:0]   an_q;
    logic [6:0]              seg_q;
    logic                    dp_q, tick_q, ack_q;

    // Next scan position; outputs are registered from this look-ahead
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        frame_end = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_SHOW;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_SHOW: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == SHOW_LAST) state_d = ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == SLOT_LAST) begin
                    state_d   = ST_SHOW;
                    cnt_d     = '0;
                    frame_end = (idx_q == IDX_LAST);
                    idx_d     = frame_end ? '0 : idx_q + IW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Buffer swap and digit selection feeding the shared decoder
    always_comb begin
        commit   = pend_vld_q && ((state_q == ST_IDLE) || frame_end);
        act_dig_d = commit ? pend_dig_q : act_dig_q;
        act_dp_d  = commit ? pend_dp_q : act_dp_q;
        nib_d     = act_dig_d[{idx_d, 2'b00} +: 4];
        show_d    = (state_d == ST_SHOW) && !blank_mask[idx_d];
        tick_d    = (state_d == ST_BLANK) && (idx_d == IDX_LAST)
                    && (cnt_d == SLOT_LAST);
    end

    Bublik_segment u_dec (
        .hex_i (nib_d),
        .seg_o (dec_seg)
    );

    // Scan state, buffers and registered display outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            act_dig_q  <= '0;
            act_dp_q   <= '0;
            pend_dig_q <= '0;
            pend_dp_q  <= '0;
            pend_vld_q <= 1'b0;
            an_q       <= '0;
            seg_q      <= SEG_OFF;
            dp_q       <= 1'b0;
            tick_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            act_dig_q <= act_dig_d;
            act_dp_q  <= act_dp_d;
            if (load) begin
                pend_dig_q <= digits_in;
                pend_dp_q  <= dp_in;
                pend_vld_q <= 1'b1;
            end else if (commit) begin
                pend_vld_q <= 1'b0;
            end
            an_q   <= show_d ? (NUM_DIGITS'(1) << idx_d) : '0;
            seg_q  <= show_d ? dec_seg : SEG_OFF;
            dp_q   <= show_d && act_dp_d[idx_d];
            tick_q <= tick_d;
            ack_q  <= commit;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = tick_q;
    assign load_ack   = ack_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.
// Expected display samples, acks and frame ticks are queued by cycle number.
module tb_seg_scan_ctrl;

    localparam logic [6:0] G1 = 7'b0110000;
    localparam logic [6:0] G2 = 7'b1101101;
    localparam logic [6:0] G3 = 7'b1111001;
    localparam logic [6:0] G4 = 7'b0110011;
    localparam logic [6:0] G5 = 7'b1011011;
    localparam logic [6:0] G6 = 7'b1011111;
    localparam logic [6:0] GC = 7'b1001110;
    localparam logic [6:0] GD = 7'b0111101;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        string      tag;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_mask;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;
    logic        load_ack;

    int   cyc  = 0;
    int   nvec = 0;
    int   nbad = 0;
    obs_t obsq[$];
    int   ackq[$];
    int   ftq[$];

    seg_scan_ctrl #(
        .NUM_DIGITS   (4),
        .PRESCALE     (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank_mask (blank_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick),
        .load_ack   (load_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_obs(input int c, input logic [3:0] a,
                            input logic [6:0] s, input logic d,
                            input string t);
        obs_t o;
        o.cyc = c;
        o.an  = a;
        o.seg = s;
        o.dp  = d;
        o.tag = t;
        obsq.push_back(o);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: compare whatever the DUT presents against the queues
    always @(negedge clk) begin
        for (int i = obsq.size() - 1; i >= 0; i--) begin
            if (obsq[i].cyc <= cyc) begin
                nvec++;
                if (obsq[i].cyc < cyc) begin
                    nbad++;
                    $display("FAIL %s: sample missed at cycle %0d, wanted cycle %0d",
                             obsq[i].tag, cyc, obsq[i].cyc);
                end else if (an !== obsq[i].an || seg !== obsq[i].seg
                             || dp !== obsq[i].dp) begin
                    nbad++;
                    $display("FAIL %s @%0d: an=%b seg=%b dp=%b, required an=%b seg=%b dp=%b",
                             obsq[i].tag, cyc, an, seg, dp,
                             obsq[i].an, obsq[i].seg, obsq[i].dp);
                end
                obsq.delete(i);
            end
        end
        if (ackq.size() > 0 && ackq[0] < cyc) begin
            nvec++;
            nbad++;
            $display("FAIL load_ack: none at cycle %0d, required 1", ackq[0]);
            void'(ackq.pop_front());
        end
        if (load_ack === 1'b1) begin
            nvec++;
            if (ackq.size() > 0 && ackq[0] == cyc) begin
                void'(ackq.pop_front());
            end else begin
                nbad++;
                $display("FAIL load_ack: pulse at cycle %0d, required 0", cyc);
            end
        end
        if (ftq.size() > 0 && ftq[0] < cyc) begin
            nvec++;
            nbad++;
            $display("FAIL frame_tick: none at cycle %0d, required 1", ftq[0]);
            void'(ftq.pop_front());
        end
        if (frame_tick === 1'b1) begin
            nvec++;
            if (ftq.size() > 0 && ftq[0] == cyc) begin
                void'(ftq.pop_front());
            end else begin
                nbad++;
                $display("FAIL frame_tick: pulse at cycle %0d, required 0", cyc);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int s2;
        rst_n      = 1'b0;
        enable     = 1'b1;
        load       = 1'b1;
        digits_in  = 16'hFFFF;
        dp_in      = 4'hF;
        blank_mask = 4'b0000;
        for (int c = 1; c <= 3; c++) push_obs(c, 4'b0, 7'b0, 1'b0, "reset");

        wait_until(3);
        rst_n  = 1'b1;
        enable = 1'b0;
        load   = 1'b0;

        // idle load commits without scanning
        wait_until(5);
        digits_in = 16'h1234;
        dp_in     = 4'b0010;
        load      = 1'b1;
        ackq.push_back(7);
        wait_until(6);
        load = 1'b0;

        wait_until(8);
        enable = 1'b1;
        s = 9;
        for (int k = 0; k < 6; k++) ftq.push_back(s + 31 + 32 * k);
        push_obs(s,       4'b0001, G4, 1'b0, "s0_first");
        push_obs(s + 5,   4'b0001, G4, 1'b0, "s0_last");
        push_obs(s + 6,   4'b0000, 7'b0, 1'b0, "s0_blank_a");
        push_obs(s + 7,   4'b0000, 7'b0, 1'b0, "s0_blank_b");
        push_obs(s + 8,   4'b0010, G3, 1'b1, "s1_dp");
        push_obs(s + 16,  4'b0100, G2, 1'b0, "s2");
        push_obs(s + 24,  4'b1000, G1, 1'b0, "s3");
        push_obs(s + 31,  4'b0000, 7'b0, 1'b0, "frame_blank");
        push_obs(s + 48,  4'b0100, G2, 1'b0, "hold_old");
        push_obs(s + 64,  4'b0001, GD, 1'b0, "abcd_s0");
        push_obs(s + 72,  4'b0010, GC, 1'b0, "abcd_s1");
        push_obs(s + 96,  4'b0001, G2, 1'b0, "last_wins_s0");
        push_obs(s + 104, 4'b0010, G2, 1'b0, "last_wins_s1");
        push_obs(s + 112, 4'b0100, G2, 1'b0, "last_wins_s2");
        push_obs(s + 120, 4'b0000, 7'b0, 1'b0, "mask_s3_a");
        push_obs(s + 125, 4'b0000, 7'b0, 1'b0, "mask_s3_b");
        push_obs(s + 127, 4'b0000, 7'b0, 1'b0, "mask_s3_c");
        push_obs(s + 152, 4'b1000, G2, 1'b0, "unmask_s3");
        push_obs(s + 160, 4'b0001, G5, 1'b0, "old_pend_s0");
        push_obs(s + 192, 4'b0001, G6, 1'b0, "new_pend_s0");
        push_obs(s + 210, 4'b0000, 7'b0, 1'b0, "disabled");

        // mid-frame load waits for the frame boundary
        wait_until(s + 40);
        digits_in = 16'hABCD;
        dp_in     = 4'b0000;
        load      = 1'b1;
        ackq.push_back(s + 64);
        wait_until(s + 41);
        load = 1'b0;

        // two loads in one frame, one ack
        wait_until(s + 66);
        digits_in = 16'h1111;
        load      = 1'b1;
        wait_until(s + 67);
        load = 1'b0;
        wait_until(s + 76);
        digits_in = 16'h2222;
        load      = 1'b1;
        ackq.push_back(s + 96);
        wait_until(s + 77);
        load = 1'b0;

        // live blanking of the leftmost digit
        wait_until(s + 100);
        blank_mask = 4'b1000;
        wait_until(s + 130);
        blank_mask = 4'b0000;

        // load colliding with the frame-end commit
        wait_until(s + 140);
        digits_in = 16'h5555;
        load      = 1'b1;
        ackq.push_back(s + 160);
        wait_until(s + 141);
        load = 1'b0;
        wait_until(s + 159);
        digits_in = 16'h6666;
        load      = 1'b1;
        ackq.push_back(s + 192);
        wait_until(s + 160);
        load = 1'b0;

        // disable mid-slot, then restart from slot 0
        wait_until(s + 209);
        enable = 1'b0;
        wait_until(s + 215);
        enable = 1'b1;
        s2 = s + 216;
        ftq.push_back(s2 + 31);
        push_obs(s2,     4'b0001, G6, 1'b0, "restart_s0");
        push_obs(s2 + 8, 4'b0010, G6, 1'b0, "restart_s1");

        wait_until(s2 + 36);
        @(negedge clk);
        foreach (obsq[i]) begin
            nvec++;
            nbad++;
            $display("FAIL %s: sample at cycle %0d never checked", obsq[i].tag, obsq[i].cyc);
        end
        foreach (ackq[i]) begin
            nvec++;
            nbad++;
            $display("FAIL load_ack: none at cycle %0d, required 1", ackq[i]);
        end
        foreach (ftq[i]) begin
            nvec++;
            nbad++;
            $display("FAIL frame_tick: none at cycle %0d, required 1", ftq[i]);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
